// File: rtl/down_count_timer_if.sv
// ============================================================================
// down_count_timer_if : control/status bundle for the down-counting timer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface down_count_timer_if #(
    parameter int WIDTH = 4
) ();
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic             clr;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             expired;

    modport master (
        output load, load_val, en, auto_reload, clr,
        input  count, busy, done, expired
    );

    modport slave (
        input  load, load_val, en, auto_reload, clr,
        output count, busy, done, expired
    );
endinterface

`default_nettype wire

// File: rtl/down_count_timer.sv
// ============================================================================
// down_count_timer : loadable down counter with one-shot / periodic modes
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module down_count_timer #(
    parameter int WIDTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    down_count_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_done;
    logic             r_busy;
    logic             r_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_reload  <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_expired <= 1'b0;
        end else if (bus.load) begin
            // Load restarts from any state and swallows a coincident terminal.
            r_count   <= bus.load_val;
            r_reload  <= bus.load_val;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
            if (bus.load_val != '0) begin
                r_state <= ST_RUN;
                r_busy  <= 1'b1;
            end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (bus.en) begin
                        if (r_count > c_one) begin
                            r_count <= r_count - c_one;
                        end else begin
                            r_done <= 1'b1;
                            if (bus.auto_reload) begin
                                r_count <= r_reload;
                            end else begin
                                r_count   <= '0;
                                r_state   <= ST_EXPIRED;
                                r_busy    <= 1'b0;
                                r_expired <= 1'b1;
                            end
                        end
                    end
                end
                ST_EXPIRED: begin
                    if (bus.clr) begin
                        r_state   <= ST_IDLE;
                        r_expired <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.count   = r_count;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.expired = r_expired;

endmodule

`default_nettype wire

// File: tb/tb_down_count_timer.sv
// ============================================================================
// tb_down_count_timer : directed bench with a cycle-level reference model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_down_count_timer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    down_count_timer_if #(.WIDTH(4)) bus ();

    down_count_timer #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 = idle, 1 = running, 2 = expired.
    int m_count;
    int m_reload;
    int m_phase;
    int m_done;

    initial begin
        m_count = 0; m_reload = 0; m_phase = 0; m_done = 0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count = 0; m_reload = 0; m_phase = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (bus.load) begin
                m_count  = int'(bus.load_val);
                m_reload = int'(bus.load_val);
                m_phase  = (bus.load_val != 0) ? 1 : 0;
            end else if (m_phase == 2 && bus.clr) begin
                m_phase = 0;
            end else if (m_phase == 1 && bus.en) begin
                if (m_count == 1) begin
                    m_done = 1;
                    if (bus.auto_reload) m_count = m_reload;
                    else begin
                        m_count = 0;
                        m_phase = 2;
                    end
                end else begin
                    m_count = m_count - 1;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_count",   int'(bus.count),   m_count);
        check("model_busy",    int'(bus.busy),    (m_phase == 1) ? 1 : 0);
        check("model_done",    int'(bus.done),    m_done);
        check("model_expired", int'(bus.expired), (m_phase == 2) ? 1 : 0);
    end

    // Apply one cycle of inputs; returns just after the following falling edge.
    task automatic tick(input logic l, input logic [3:0] lv, input logic e,
                        input logic ar, input logic c);
        bus.load = l; bus.load_val = lv; bus.en = e;
        bus.auto_reload = ar; bus.clr = c;
        @(negedge clk);
    endtask

    task automatic check_outs(input string name, input int c, input int b,
                              input int d, input int x);
        check({name, "_count"},   int'(bus.count),   c);
        check({name, "_busy"},    int'(bus.busy),    b);
        check({name, "_done"},    int'(bus.done),    d);
        check({name, "_expired"}, int'(bus.expired), x);
    endtask

    initial begin
        int first_done;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.load = 0; bus.load_val = 0; bus.en = 0; bus.auto_reload = 0; bus.clr = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_outs("reset", 0, 0, 0, 0);

        // Async reset in the middle of a count.
        tick(1, 4'd9, 0, 0, 0);
        check_outs("load9", 9, 1, 0, 0);
        repeat (3) tick(0, 4'd0, 1, 0, 0);
        check("midcount_count", int'(bus.count), 6);
        #2 rst = 1'b1;
        #1 check_outs("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // One-shot.
        tick(1, 4'd5, 0, 0, 0);
        check("os_load", int'(bus.count), 5);
        for (int i = 4; i >= 1; i--) begin
            tick(0, 4'd0, 1, 0, 0);
            check_outs("os_step", i, 1, 0, 0);
        end
        tick(0, 4'd0, 1, 0, 0);
        check_outs("os_terminal", 0, 0, 1, 1);
        repeat (3) tick(0, 4'd0, 1, 0, 0);
        check_outs("os_hold", 0, 0, 0, 1);
        tick(0, 4'd0, 0, 0, 1);
        check_outs("os_clr", 0, 0, 0, 0);

        // Periodic with enable gaps.
        tick(1, 4'd3, 0, 1, 0);
        check_outs("per_load", 3, 1, 0, 0);
        tick(0, 4'd0, 1, 1, 0);
        check_outs("per_e1", 2, 1, 0, 0);
        tick(0, 4'd0, 0, 1, 0);
        check_outs("per_gap", 2, 1, 0, 0);
        tick(0, 4'd0, 1, 1, 0);
        check_outs("per_e2", 1, 1, 0, 0);
        tick(0, 4'd0, 1, 1, 0);
        check_outs("per_reload", 3, 1, 1, 0);
        tick(0, 4'd0, 1, 1, 0);
        check_outs("per_after", 2, 1, 0, 0);

        // Load colliding with the terminal edge.
        tick(1, 4'd4, 0, 0, 0);
        repeat (3) tick(0, 4'd0, 1, 0, 0);
        check("col_pre", int'(bus.count), 1);
        tick(1, 4'd7, 1, 0, 0);
        check_outs("collision", 7, 1, 0, 0);

        // Load zero.
        tick(1, 4'd0, 0, 0, 0);
        check_outs("load0", 0, 0, 0, 0);
        tick(0, 4'd0, 1, 0, 0);
        check_outs("load0_en", 0, 0, 0, 0);

        // Max value: done on exactly the 15th enabled edge.
        tick(1, 4'd15, 0, 0, 0);
        first_done = -1;
        for (int i = 1; i <= 20; i++) begin
            tick(0, 4'd0, 1, 0, 0);
            if (bus.done && first_done < 0) first_done = i;
        end
        check("max_done_edge", first_done, 15);

        // Reload value 1 in periodic mode.
        tick(1, 4'd1, 0, 1, 0);
        check_outs("rel1_load", 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 4'd0, 1, 1, 0);
            check_outs("rel1_pulse", 1, 1, 1, 0);
        end
        tick(0, 4'd0, 0, 1, 0);
        check_outs("rel1_gap", 1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
